pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central hazard controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). Computes EX-stage forwarding selects,
//  inserts load-use bubbles, flushes wrong-path instructions on taken branches/jumps, and freezes the whole pipeline
//  while data memory is busy, with a timeout watchdog. Exposes saturating stall/flush performance counters to top level.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before watchdog fires (>=2)
//  CNT_W        32  width of performance counters
// PORTS
//  clk            in   1      system clock, rising edge
//  rst            in   1      synchronous reset, active-high
//  id_rs1,id_rs2  in   5      source regs of instruction in ID
//  id_use_rs1/2   in   1      ID instruction actually reads rs1 / rs2
//  ex_rs1,ex_rs2  in   5      source regs of instruction in EX
//  ex_rd          in   5      dest reg of instruction in EX
//  ex_mem_read    in   1      EX instruction is a load
//  ex_br_taken    in   1      branch/jump in EX resolved taken
//  mem_rd,wb_rd   in   5      dest regs in MEM / WB
//  mem_reg_wr     in   1      MEM instruction writes register file
//  wb_reg_wr      in   1      WB instruction writes register file
//  dmem_req       in   1      MEM instruction accessing data memory this cycle
//  dmem_ready     in   1      data memory completes access this cycle
//  pc_en          out  1      PC update enable
//  ifid_en        out  1      IF/ID register load enable
//  ifid_flush     out  1      clear IF/ID to NOP
//  idex_flush     out  1      clear ID/EX to NOP (bubble)
//  pipe_freeze    out  1      hold EX/MEM and MEM/WB registers
//  fwd_a,fwd_b    out  2      EX operand select: 00 regfile, 01 WB, 10 MEM
//  mem_timeout    out  1      one-cycle pulse when watchdog fires
//  mem_err        out  1      sticky timeout flag, cleared only by rst
//  stall_cnt      out  CNT_W  cycles with pc_en=0
//  flush_cnt      out  CNT_W  taken-branch flush events
// BEHAVIOUR
//  - FSM states RUN, MEM_WAIT. Reset: state=RUN, wait counter=0, mem_err=0, stall_cnt=flush_cnt=0.
//  - Outputs combinational from state+inputs; after reset with all inputs 0: pc_en=ifid_en=1, others 0.
//  - Forwarding (all states): fwd_a=10 if mem_reg_wr && mem_rd!=0 && mem_rd==ex_rs1; else 01 if wb_reg_wr &&
//    wb_rd!=0 && wb_rd==ex_rs1; else 00. fwd_b identical on ex_rs2. MEM beats WB when both match. x0 never forwarded.
//  - Priority per cycle: freeze > branch flush > load-use stall.
//  - Freeze: RUN with dmem_req && !dmem_ready -> pipe_freeze=1, pc_en=ifid_en=0, flushes=0; next state MEM_WAIT.
//    MEM_WAIT: same outputs while !dmem_ready; dmem_ready=1 -> outputs revert to RUN decoding same cycle, next RUN.
//    dmem_req && dmem_ready in RUN = zero-cycle access, no freeze.
//  - Watchdog: wait counter increments each MEM_WAIT cycle; at MEM_TIMEOUT-1 with !dmem_ready, mem_timeout=1 that
//    cycle, mem_err set next edge, next state RUN, counter cleared. Freeze still asserted in the timeout cycle.
//    Counter clears on every exit from MEM_WAIT.
//  - Branch flush (not frozen, ex_br_taken=1): ifid_flush=1, idex_flush=1, pc_en=ifid_en=1 (PC loads target);
//    load-use ignored that cycle (younger instructions are discarded). flush_cnt +1.
//  - Load-use (not frozen, no flush): ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) ||
//    (id_use_rs2 && id_rs2==ex_rd)) -> pc_en=ifid_en=0, idex_flush=1, exactly one bubble.
//  - stall_cnt +1 every cycle pc_en=0 (freeze or load-use). Both counters saturate at all-ones, no wrap.
//  - rst mid-MEM_WAIT: next cycle RUN, freeze drops, counters and mem_err cleared.
// TESTING
//  1 Reset 3 cycles, inputs 0 -> pc_en=ifid_en=1, flush/freeze=0, fwd=00, counters 0, mem_err=0.
//  2 ex_rs1=5, mem_rd=5,mem_reg_wr=1, wb_rd=5,wb_reg_wr=1 -> fwd_a=10; mem_rd=0 -> fwd_a=01; ex_rs1=0 -> fwd_a=00.
//  3 ex_mem_read=1, ex_rd=7, id_rs2=7, id_use_rs2=1 -> 1 cycle pc_en=0, idex_flush=1; stall_cnt=1.
//    Repeat with ex_br_taken=1 -> no stall, ifid_flush=idex_flush=1, flush_cnt=1, stall_cnt unchanged.
//  4 dmem_req=1, dmem_ready low 4 cycles then high -> pipe_freeze=1 for 4 cycles, drops on ready cycle,
//    stall_cnt=4, mem_err=0; same cycle ex_br_taken=1 during freeze -> no flush until freeze ends.
//  5 MEM_TIMEOUT=16, dmem_req=1, dmem_ready held 0 -> mem_timeout pulse in 16th frozen cycle, mem_err=1 after,
//    pipeline resumes; mem_err stays 1 until rst.
//  6 rst asserted in 3rd MEM_WAIT cycle -> next cycle state RUN, freeze=0, stall_cnt=0; saturate check with CNT_W=4:
//    20 load-use stalls -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX forwarding selects, load-use bubbles,
// taken-branch flushes and a data-memory freeze with watchdog, plus saturating perf counters.

module hazard_fwd_sel (
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_wr,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_wr,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (mem_reg_wr && mem_rd != 5'd0 && mem_rd == ex_rs)   sel = 2'b10;
    else if (wb_reg_wr && wb_rd != 5'd0 && wb_rd == ex_rs) sel = 2'b01;
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_wr,
  input  logic             wb_reg_wr,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int              NUM_OPS = 2;
  localparam int              WC_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t                        state;
  logic [WC_W-1:0]               wait_cnt;
  logic [NUM_OPS-1:0][4:0]       ex_rs;
  logic [NUM_OPS-1:0][1:0]       fwd_sel;
  logic                          frozen, timeout_hit, flush, load_use;

  assign ex_rs = {ex_rs2, ex_rs1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    hazard_fwd_sel u_fwd (
      .ex_rs      (ex_rs[i]),
      .mem_rd     (mem_rd),
      .mem_reg_wr (mem_reg_wr),
      .wb_rd      (wb_rd),
      .wb_reg_wr  (wb_reg_wr),
      .sel        (fwd_sel[i])
    );
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  // Freeze wins over flush, flush wins over load-use.
  assign frozen      = !dmem_ready && ((state == RUN && dmem_req) || state == MEM_WAIT);
  assign timeout_hit = (state == MEM_WAIT) && !dmem_ready && (wait_cnt == WC_LAST);
  assign flush       = !frozen && ex_br_taken;
  assign load_use    = !frozen && !ex_br_taken && ex_mem_read && ex_rd != 5'd0 &&
                       ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  assign pc_en       = !(frozen || load_use);
  assign ifid_en     = pc_en;
  assign ifid_flush  = flush;
  assign idex_flush  = flush || load_use;
  assign pipe_freeze = frozen;
  assign mem_timeout = timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        // wait_cnt counts frozen cycles so far, the RUN entry cycle included
        RUN: if (dmem_req && !dmem_ready) begin
          state    <= MEM_WAIT;
          wait_cnt <= WC_W'(1);
        end
        MEM_WAIT: if (dmem_ready || timeout_hit) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
      if (timeout_hit)                 mem_err   <= 1'b1;
      if (!pc_en && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)    flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a CNT_W=4 copy shares the stimulus for saturation.

module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_reg_wr, wb_reg_wr, dmem_req, dmem_ready;

  logic pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, mem_timeout, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic pc_en4, ifid_en4, ifid_flush4, idex_flush4, pipe_freeze4, mem_timeout4, mem_err4;
  logic [1:0] fwd_a4, fwd_b4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int pass_n = 0;
  int chk_n  = 0;

  // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, fwd_a, fwd_b, mem_timeout}
  wire [9:0] ctl = {pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, fwd_a, fwd_b, mem_timeout};
  localparam logic [9:0] CTL_IDLE   = 10'b11_0_0_0_00_00_0;
  localparam logic [9:0] CTL_LU     = 10'b00_0_1_0_00_00_0;
  localparam logic [9:0] CTL_BR     = 10'b11_1_1_0_00_00_0;
  localparam logic [9:0] CTL_FREEZE = 10'b00_0_0_1_00_00_0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_freeze(pipe_freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .pipe_freeze(pipe_freeze4), .fwd_a(fwd_a4), .fwd_b(fwd_b4), .mem_timeout(mem_timeout4),
    .mem_err(mem_err4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_br_taken = 0;
    mem_rd = 0; wb_rd = 0; mem_reg_wr = 0; wb_reg_wr = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1; tick(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0; #1;
    chk_n++; if (ctl !== CTL_IDLE) $display("FAIL reset_ctl got %b exp %b", ctl, CTL_IDLE); else pass_n++;
    chk_n++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall got %0d exp 0", stall_cnt); else pass_n++;
    chk_n++; if (flush_cnt !== 32'd0) $display("FAIL reset_flush got %0d exp 0", flush_cnt); else pass_n++;
    chk_n++; if (mem_err !== 1'b0) $display("FAIL reset_mem_err got %b exp 0", mem_err); else pass_n++;
  endtask

  task automatic test_forwarding();
    do_reset();
    ex_rs1 = 5; mem_rd = 5; mem_reg_wr = 1; wb_rd = 5; wb_reg_wr = 1; #1;
    chk_n++; if (fwd_a !== 2'b10) $display("FAIL fwd_mem_prio got %b exp 10", fwd_a); else pass_n++;
    mem_rd = 0; #1;
    chk_n++; if (fwd_a !== 2'b01) $display("FAIL fwd_wb got %b exp 01", fwd_a); else pass_n++;
    ex_rs1 = 0; wb_rd = 0; #1;
    chk_n++; if (fwd_a !== 2'b00) $display("FAIL fwd_x0 got %b exp 00", fwd_a); else pass_n++;
    ex_rs2 = 9; mem_rd = 9; mem_reg_wr = 0; wb_rd = 9; wb_reg_wr = 1; #1;
    chk_n++; if (fwd_b !== 2'b01) $display("FAIL fwdb_wb got %b exp 01", fwd_b); else pass_n++;
    mem_reg_wr = 1; #1;
    chk_n++; if (fwd_b !== 2'b10) $display("FAIL fwdb_mem got %b exp 10", fwd_b); else pass_n++;
    mem_reg_wr = 0; wb_reg_wr = 0; #1;
    chk_n++; if (fwd_b !== 2'b00) $display("FAIL fwdb_nowr got %b exp 00", fwd_b); else pass_n++;
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
    chk_n++; if (ctl !== CTL_IDLE) $display("FAIL lu_x0 got %b exp %b", ctl, CTL_IDLE); else pass_n++;
    clear_inputs();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #1;
    chk_n++; if (ctl !== CTL_LU) $display("FAIL lu_stall got %b exp %b", ctl, CTL_LU); else pass_n++;
    tick();
    clear_inputs(); #1;
    chk_n++; if (ctl !== CTL_IDLE) $display("FAIL lu_release got %b exp %b", ctl, CTL_IDLE); else pass_n++;
    chk_n++; if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); else pass_n++;
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; ex_br_taken = 1; #1;
    chk_n++; if (ctl !== CTL_BR) $display("FAIL br_over_lu got %b exp %b", ctl, CTL_BR); else pass_n++;
    tick();
    clear_inputs(); #1;
    chk_n++; if (flush_cnt !== 32'd1) $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); else pass_n++;
    chk_n++; if (stall_cnt !== 32'd1) $display("FAIL br_stall_cnt got %0d exp 1", stall_cnt); else pass_n++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_br_taken = 1;
    tick(); tick();
    clear_inputs(); #1;
    chk_n++; if (flush_cnt !== 32'd2) $display("FAIL b2b_flush_cnt got %0d exp 2", flush_cnt); else pass_n++;
  endtask

  task automatic test_freeze();
    do_reset();
    dmem_req = 1; dmem_ready = 0; ex_br_taken = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk_n++; if (ctl !== CTL_FREEZE) $display("FAIL freeze_c%0d got %b exp %b", k, ctl, CTL_FREEZE); else pass_n++;
      tick();
    end
    dmem_ready = 1; #1;
    chk_n++; if (ctl !== CTL_BR) $display("FAIL freeze_ready got %b exp %b", ctl, CTL_BR); else pass_n++;
    tick();
    clear_inputs(); #1;
    chk_n++; if (ctl !== CTL_IDLE) $display("FAIL freeze_after got %b exp %b", ctl, CTL_IDLE); else pass_n++;
    chk_n++; if (stall_cnt !== 32'd4) $display("FAIL freeze_stall_cnt got %0d exp 4", stall_cnt); else pass_n++;
    chk_n++; if (flush_cnt !== 32'd1) $display("FAIL freeze_flush_cnt got %0d exp 1", flush_cnt); else pass_n++;
    chk_n++; if (mem_err !== 1'b0) $display("FAIL freeze_mem_err got %b exp 0", mem_err); else pass_n++;
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk_n++; if (pipe_freeze !== 1'b1 || mem_timeout !== (k == 16))
        $display("FAIL tmo_c%0d got frz=%b tmo=%b exp frz=1 tmo=%b", k, pipe_freeze, mem_timeout, k == 16);
      else pass_n++;
      tick();
    end
    dmem_req = 0; #1;
    chk_n++; if (ctl !== CTL_IDLE) $display("FAIL tmo_resume got %b exp %b", ctl, CTL_IDLE); else pass_n++;
    chk_n++; if (mem_err !== 1'b1) $display("FAIL tmo_mem_err got %b exp 1", mem_err); else pass_n++;
    chk_n++; if (stall_cnt !== 32'd16) $display("FAIL tmo_stall_cnt got %0d exp 16", stall_cnt); else pass_n++;
    repeat (3) tick();
    chk_n++; if (mem_err !== 1'b1) $display("FAIL tmo_sticky got %b exp 1", mem_err); else pass_n++;
    do_reset();
    chk_n++; if (mem_err !== 1'b0) $display("FAIL tmo_rst_clear got %b exp 0", mem_err); else pass_n++;
  endtask

  task automatic test_rst_mid_wait();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (3) tick();
    rst = 1'b1; #1;
    chk_n++; if (pipe_freeze !== 1'b1) $display("FAIL mid_pre got %b exp 1", pipe_freeze); else pass_n++;
    tick();
    rst = 1'b0; dmem_req = 0; #1;
    chk_n++; if (ctl !== CTL_IDLE) $display("FAIL mid_run got %b exp %b", ctl, CTL_IDLE); else pass_n++;
    chk_n++; if (stall_cnt !== 32'd0) $display("FAIL mid_stall_cnt got %0d exp 0", stall_cnt); else pass_n++;
    // a fresh wait must not inherit the old watchdog count
    dmem_req = 1;
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk_n++; if (mem_timeout !== 1'b0) $display("FAIL mid_wd_c%0d got %b exp 0", k, mem_timeout); else pass_n++;
      tick();
    end
    dmem_ready = 1; tick(); clear_inputs(); #1;
  endtask

  task automatic test_saturate();
    do_reset();
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    repeat (20) tick();
    clear_inputs(); #1;
    chk_n++; if (stall_cnt4 !== 4'hF) $display("FAIL sat_stall4 got %0d exp 15", stall_cnt4); else pass_n++;
    chk_n++; if (stall_cnt !== 32'd20) $display("FAIL sat_stall32 got %0d exp 20", stall_cnt); else pass_n++;
    ex_br_taken = 1;
    repeat (18) tick();
    clear_inputs(); #1;
    chk_n++; if (flush_cnt4 !== 4'hF) $display("FAIL sat_flush4 got %0d exp 15", flush_cnt4); else pass_n++;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_back_to_back();
    test_freeze();
    test_timeout();
    test_rst_mid_wait();
    test_saturate();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
